// File: rtl/reg_ab_alu_io_pkg.sv
// Shared types for the nibble datapath slice: default width, ALU op, IB source.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package reg_ab_alu_io_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_IN   = 2'd2,
    SRC_A    = 2'd3
  } ib_src_e;

  // Priority encoder for the internal bus: ALU beats DataIn beats regA.
  // Overlapping enables from the sequencer are resolved here, never as a
  // bus fight.
  function automatic ib_src_e ib_select(input logic en_alu,
                                        input logic en_in,
                                        input logic en_a);
    ib_src_e src;
    if (en_alu)     src = SRC_ALU;
    else if (en_in) src = SRC_IN;
    else if (en_a)  src = SRC_A;
    else            src = SRC_NONE;
    return src;
  endfunction

endpackage

// File: rtl/reg_ab_alu_io_datapath_alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor: result = b + a or b - a, plus carry.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   op     : OP_ADD -> b + a, OP_SUB -> b + ~a + 1
//   a, b   : operands
//   result : sum modulo 2^WIDTH
//   carry  : carry out of the top bit (for subtract, 1 = no borrow)
module alu_addsub
  import reg_ab_alu_io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] a_opnd;
  logic             cin;
  logic [WIDTH:0]   sum_full;

  // Subtract is done as b + ~a + 1 so one adder chain serves both ops and
  // the carry keeps its "no borrow" meaning.
  always_comb begin
    cin      = (op == OP_SUB);
    a_opnd   = cin ? ~a : a;
    sum_full = {1'b0, b} + {1'b0, a_opnd} + {{WIDTH{1'b0}}, cin};
    result   = sum_full[WIDTH-1:0];
    carry    = sum_full[WIDTH];
  end

endmodule

// File: rtl/reg_ab_alu_io_datapath.sv
// Nibble datapath slice: regA, regB, add/sub ALU, input port and output register on one internal bus.
// Latency: register loads and DataOut capture take 1 cycle; IB (and optional flags) are combinational.
// Backpressure: none; the control sequencer owns all strobes and every enable combination is legal.
//
// Ports:
//   MainClock, invMainReset : clock (rising edge) and async active-low reset
//   A, B, LatchA, LatchB    : operand load values and their load enables
//   AddSub                  : 0 = B + A, 1 = B - A
//   EnableAlu/EnableIn/EnableA : IB source enables, priority ALU > In > A
//   DataIn                  : external input data
//   EnableOut               : DataOut loads IB
//   IB                      : internal bus (0 when nothing drives it)
//   DataOut                 : output register
// Optional build macro ALU_FLAGS_EN adds CarryOut and Zero (ALU flags,
// independent of EnableAlu).
module reg_ab_alu_io_datapath
  import reg_ab_alu_io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             MainClock,
  input  logic             invMainReset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             LatchA,
  input  logic             LatchB,
  input  logic             AddSub,
  input  logic             EnableAlu,
  input  logic             EnableA,
  input  logic             EnableIn,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             EnableOut,
`ifdef ALU_FLAGS_EN
  output logic             CarryOut,
  output logic             Zero,
`endif
  output logic [WIDTH-1:0] IB,
  output logic [WIDTH-1:0] DataOut
);

  logic [WIDTH-1:0] rega;
  logic [WIDTH-1:0] regb;
  logic [WIDTH-1:0] alu_result;
  ib_src_e          ib_src;

  // Operand registers. Reset wins over any load.
  always_ff @(posedge MainClock or negedge invMainReset) begin
    if (!invMainReset) begin
      rega <= '0;
      regb <= '0;
    end else begin
      if (LatchA) rega <= A;
      if (LatchB) regb <= B;
    end
  end

`ifdef ALU_FLAGS_EN
  logic alu_carry;

  alu_addsub #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op_e'(AddSub)),
    .a      (rega),
    .b      (regb),
    .result (alu_result),
    .carry  (alu_carry)
  );

  assign CarryOut = alu_carry;
  assign Zero     = (alu_result == '0);
`else
  // Carry has no consumer in this build.
  alu_addsub #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op_e'(AddSub)),
    .a      (rega),
    .b      (regb),
    .result (alu_result),
    .carry  ()
  );
`endif

  // Internal bus: a plain mux, so conflicting enables resolve by priority
  // and an idle bus reads as 0 rather than floating.
  always_comb begin
    ib_src = ib_select(EnableAlu, EnableIn, EnableA);
    IB     = '0;
    case (ib_src)
      SRC_ALU:  IB = alu_result;
      SRC_IN:   IB = DataIn;
      SRC_A:    IB = rega;
      default:  IB = '0;
    endcase
  end

  // Output register samples the pre-edge bus, so a same-cycle load of regA
  // is not seen until the following capture.
  always_ff @(posedge MainClock or negedge invMainReset) begin
    if (!invMainReset) begin
      DataOut <= '0;
    end else if (EnableOut) begin
      DataOut <= IB;
    end
  end

endmodule

// File: tb/tb_reg_ab_alu_io_datapath.sv
// Self-checking bench for reg_ab_alu_io_datapath: directed vector table plus
// hand-written reset and first-load sequences.
module tb_reg_ab_alu_io_datapath;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b, din;
  logic         la, lb, sub, ealu, ea, ein, eout;
  logic [W-1:0] ib, dout;
`ifdef ALU_FLAGS_EN
  logic         carry, zero;
`endif

  int n_tests;
  int n_fail;

  reg_ab_alu_io_datapath #(.WIDTH(W)) dut (
    .MainClock    (clk),
    .invMainReset (rst_n),
    .A            (a),
    .B            (b),
    .LatchA       (la),
    .LatchB       (lb),
    .AddSub       (sub),
    .EnableAlu    (ealu),
    .EnableA      (ea),
    .EnableIn     (ein),
    .DataIn       (din),
    .EnableOut    (eout),
`ifdef ALU_FLAGS_EN
    .CarryOut     (carry),
    .Zero         (zero),
`endif
    .IB           (ib),
    .DataOut      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         la;
    logic [W-1:0] a;
    logic         lb;
    logic [W-1:0] b;
    logic         sub;
    logic         ealu;
    logic         ein;
    logic         ea;
    logic [W-1:0] din;
    logic         eout;
    logic [W-1:0] exp_ib;    // IB before the edge
    logic [W-1:0] exp_dout;  // DataOut after the edge
    logic         exp_c;
    logic         exp_z;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    la = 0; lb = 0; a = '0; b = '0; sub = 0;
    ealu = 0; ein = 0; ea = 0; din = '0; eout = 0;
  endtask

  initial begin
    // la a lb b sub ealu ein ea din eout | ib dout c z
    vec[0]  = '{0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1};
    vec[1]  = '{1, 4'h3, 1, 4'h4, 0, 1, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0, 1};
    vec[2]  = '{0, 4'h0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 4'h7, 4'h7, 0, 0};
    vec[3]  = '{1, 4'h3, 1, 4'h2, 1, 1, 0, 0, 4'h0, 0, 4'h1, 4'h7, 1, 0};
    vec[4]  = '{0, 4'h0, 0, 4'h0, 1, 1, 0, 0, 4'h0, 1, 4'hF, 4'hF, 0, 0};
    vec[5]  = '{1, 4'h5, 1, 4'h5, 1, 1, 0, 0, 4'h0, 0, 4'hF, 4'hF, 0, 0};
    vec[6]  = '{0, 4'h0, 0, 4'h0, 1, 1, 0, 0, 4'h0, 1, 4'h0, 4'h0, 1, 1};
    vec[7]  = '{1, 4'h9, 1, 4'h8, 0, 1, 0, 0, 4'h0, 0, 4'hA, 4'h0, 0, 0};
    vec[8]  = '{0, 4'h0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 4'h1, 4'h1, 1, 0};
    vec[9]  = '{1, 4'h3, 0, 4'h0, 0, 0, 1, 1, 4'hA, 1, 4'hA, 4'hA, 1, 0};
    vec[10] = '{0, 4'h0, 0, 4'h0, 0, 1, 1, 1, 4'hA, 1, 4'hB, 4'hB, 0, 0};
    vec[11] = '{0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 4'h3, 4'hB, 0, 0};
    vec[12] = '{1, 4'h2, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 4'h3, 4'hB, 0, 0};
    vec[13] = '{1, 4'h7, 0, 4'h0, 0, 0, 0, 1, 4'h0, 1, 4'h2, 4'h2, 0, 0};
    vec[14] = '{0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 1, 4'h7, 4'h7, 0, 0};
    vec[15] = '{0, 4'h0, 0, 4'h0, 1, 1, 1, 0, 4'h0, 1, 4'h1, 4'h1, 1, 0};
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst_n = 1'b0;

    // Reset state: everything cleared, idle bus reads 0, ALU of zeros is 0.
    #2;
    check("reset_dout", dout, 4'h0);
    check("reset_ib_idle", ib, 4'h0);
    ealu = 1;
    #1;
    check("reset_ib_alu", ib, 4'h0);
    ealu = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      la = vec[i].la; a = vec[i].a; lb = vec[i].lb; b = vec[i].b;
      sub = vec[i].sub; ealu = vec[i].ealu; ein = vec[i].ein; ea = vec[i].ea;
      din = vec[i].din; eout = vec[i].eout;
      #1;
      check($sformatf("vec%0d_ib", i), ib, vec[i].exp_ib);
`ifdef ALU_FLAGS_EN
      check($sformatf("vec%0d_carry", i), {3'b0, carry}, {3'b0, vec[i].exp_c});
      check($sformatf("vec%0d_zero", i), {3'b0, zero}, {3'b0, vec[i].exp_z});
`endif
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_dout", i), dout, vec[i].exp_dout);
    end

    // Mid-cycle reset: preload regA=9, regB=6, DataOut=5.
    @(negedge clk);
    idle();
    la = 1; a = 4'h9; lb = 1; b = 4'h6; ein = 1; din = 4'h5; eout = 1;
    @(posedge clk);
    #1;
    idle();
    check("pre_rst_dout", dout, 4'h5);
    ea = 1;
    #1;
    check("pre_rst_rega", ib, 4'h9);
    ea = 0; ealu = 1;
    #1;
    check("pre_rst_add", ib, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 4'h0);
    check("mid_rst_add", ib, 4'h0);
    sub = 1;
    #1;
    check("mid_rst_sub", ib, 4'h0);
    ealu = 0; sub = 0; ea = 1;
    #1;
    check("mid_rst_rega", ib, 4'h0);
    ea = 0;
    #1;
    check("mid_rst_idle", ib, 4'h0);

    // A load requested while reset is held must be ignored; the first edge
    // after release must load.
    la = 1; a = 4'hC;
    @(posedge clk);
    #1;
    ea = 1;
    #1;
    check("rst_blocks_load", ib, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    la = 1; a = 4'h6;
    @(posedge clk);
    #1;
    la = 0;
    check("first_load_after_rst", ib, 4'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_ab_alu_io_datapath.md
Name: reg_ab_alu_io_datapath

Overview:
- Nibble-wide processor datapath slice: operand register A, operand register B, an add/subtract ALU, an input port and an output register, all sharing one internal bus (IB).
- A bus-source select drives IB from the ALU, the data input or register A.
- The output register captures IB.
- Sits between the control sequencer (which supplies the latch/enable strobes) and the external data pins.

Parameters:
WIDTH, 4, data width of the operand registers, ALU, internal bus and I/O ports

Ports:
MainClock  input  1  single system clock; all state changes on its rising edge
invMainReset  input  1  asynchronous active-low reset
A  input  WIDTH  operand A load value
B  input  WIDTH  operand B load value
LatchA  input  1  load enable for register A
LatchB  input  1  load enable for register B
AddSub  input  1  ALU op: 0 = add (B + A), 1 = subtract (B - A)
EnableAlu  input  1  ALU result drives IB
EnableA  input  1  register A contents drive IB
EnableIn  input  1  DataIn drives IB
DataIn  input  WIDTH  external input data
EnableOut  input  1  output register loads IB
IB  output  WIDTH  internal bus value (combinational)
DataOut  output  WIDTH  output register contents

Behaviour:
- Reset: invMainReset low clears regA, regB and DataOut to 0 immediately, regardless of the clock. Reset has priority over every load. Release is synchronous-safe: the first load can happen on the first rising edge after deassertion.
- regA: on a rising MainClock edge with LatchA=1, regA <= A. Otherwise it holds.
- regB: on a rising MainClock edge with LatchB=1, regB <= B. Otherwise it holds.
- The clock is not gated. Enables are sampled at the rising edge. Loads take 1-cycle latency, and the new value is visible after the edge.
- ALU is combinational.
  - sum = regB + (AddSub ? ~regA : regA) + AddSub, truncated to WIDTH bits (two's-complement modulo 2^WIDTH).
  - Carry-out is discarded in the base build.
  - Subtract wraps, e.g. B=2, A=3 gives 4'hF.
- IB is a combinational priority mux. No tri-state is used internally.
  - Priority: EnableAlu > EnableIn > EnableA.
  - With no enable active, IB = 0.
  - Simultaneous enables are legal and resolved by this priority; a control-bus conflict never produces X.
- DataOut: on a rising MainClock edge with EnableOut=1, DataOut <= IB (the IB value just before the edge). Otherwise it holds.
- Simultaneous events in the same cycle:
  - LatchA and EnableA together: IB shows the old regA, and DataOut captures the old regA.
  - The same rule applies to an ALU result that depends on registers being loaded in that cycle: all captures use pre-edge values.
- Reset mid-operation: all registers clear at once. IB then reflects the cleared registers, e.g. the ALU add result becomes 0 and a subtract becomes 0.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, two extra outputs are added:
  - CarryOut (1): carry out of the WIDTH-bit adder chain. For subtract, 1 means no borrow.
  - Zero (1): ALU result == 0.
  - Both are combinational and independent of EnableAlu.
- When undefined, these ports do not exist and the carry is dropped.

Decomposition:
- Shared package reg_ab_alu_io_pkg holds:
  - the WIDTH default constant;
  - a typedef for the ALU op (OP_ADD=0, OP_SUB=1);
  - an enum for the IB source (SRC_NONE, SRC_ALU, SRC_IN, SRC_A), used by the priority encoder.
- One sub-module is natural: alu_addsub, a parameterised combinational adder/subtractor producing the result and carry.
- The registers and the bus mux stay in the top module.

Test Plan:
- Reset: pulse invMainReset low mid-cycle with prior regA=9, regB=6, DataOut=5 -> all three read 0 before the next clock edge; IB=0 with all enables low.
- Add: load A=3 (LatchA), B=4 (LatchB); AddSub=0, EnableAlu=1, EnableOut=1 -> IB=7; DataOut=7 one edge later.
- Subtract with wrap: A=3, B=2, AddSub=1 -> IB=4'hF; with ALU_FLAGS_EN, CarryOut=0, Zero=0. With A=5, B=5 -> IB=0, Zero=1, CarryOut=1.
- Overflow: A=9, B=8, AddSub=0 -> IB=1 (CarryOut=1 with the flag build).
- Bus priority: DataIn=4'hA, regA=3; EnableIn=1 and EnableA=1 -> IB=4'hA; additionally EnableAlu=1 -> IB=ALU result; only EnableA -> IB=3.
- Simultaneous load/read: regA=2; A=7, LatchA=1, EnableA=1, EnableOut=1 in the same cycle -> DataOut=2 after the edge and regA=7; next cycle DataOut=7.
